// File: rtl/pc_ifid.sv
// pc_ifid: fetch front end of the five-stage pipeline.
// Holds the PC, drives the instruction-memory address combinationally from it,
// and latches the fetched word into the IF/ID register. Redirects from EX
// (taken branch) beat the load-use stall, which beats a jump from ID.
// Two saturating counters record honoured stalls and IF/ID flushes.
module pc_ifid #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Redirect targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic [31:0]      ifid_pc4_q, ifid_pc4_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]      pc_plus4;

    // Sequential PC, modulo 2^32 so 0xFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state selection: branch > stall > jump > sequential fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (branch_taken) begin
            // The stalled ID instruction is wrong-path, so the stall is dropped.
            pc_d         = word_align(branch_target);
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
            flush_cnt_d  = sat_inc(flush_cnt_q);
        end else if (stall) begin
            // Jump stays held in ID and re-asserts once the stall clears.
            stall_cnt_d  = sat_inc(stall_cnt_q);
        end else if (jump) begin
            // No delay slot: the word fetched alongside the jump is squashed.
            pc_d         = word_align(jump_target);
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
            flush_cnt_d  = sat_inc(flush_cnt_q);
        end else begin
            pc_d         = pc_plus4;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    // ---- IF -> ID stage boundary ----
    // Register update; reset overrides any stall or redirect in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
